// File: rtl/estagio_mem_if.sv
// EX/MEM -> MEM/WB bundle for the memory stage: pipeline-register inputs, redirect/stall
// outputs and the MEM/WB register contents.
interface estagio_mem_if;
  logic [31:0] aluOut;
  logic [31:0] reg2;
  logic [31:0] pcDesvio;
  logic [31:0] pcJump;
  logic        zero;
  logic        regWrite;
  logic        branch;
  logic        jump;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic [4:0]  regDest;

  logic        ctrlDesvio;
  logic [31:0] pcDestino;
  logic        parada;
  logic [31:0] dadoMemWB;
  logic [31:0] aluOutWB;
  logic        regWriteWB;
  logic        memToRegWB;
  logic [4:0]  regDestWB;
  logic        erroAlinhamento;

  modport master (
    output aluOut, reg2, pcDesvio, pcJump, zero, regWrite, branch, jump,
           memRead, memWrite, memToReg, regDest,
    input  ctrlDesvio, pcDestino, parada, dadoMemWB, aluOutWB, regWriteWB,
           memToRegWB, regDestWB, erroAlinhamento
  );

  modport slave (
    input  aluOut, reg2, pcDesvio, pcJump, zero, regWrite, branch, jump,
           memRead, memWrite, memToReg, regDest,
    output ctrlDesvio, pcDestino, parada, dadoMemWB, aluOutWB, regWriteWB,
           memToRegWB, regDestWB, erroAlinhamento
  );
endinterface

// File: rtl/estagio_mem.sv
// MEM pipeline stage: multi-cycle data memory with stall FSM, branch/jump redirect and MEM/WB register.
// Optional macro MEM_ALINHAMENTO_EN: misaligned accesses are suppressed and flagged on erroAlinhamento.
module estagio_mem #(
  parameter int unsigned LATENCIA      = 2,
  parameter int unsigned PALAVRAS_LOG2 = 8
) (
  input  logic         clock,
  input  logic         reset,
  estagio_mem_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, ACESSO, CONCLUIDO} estado_t;

  localparam int unsigned PROF    = 1 << PALAVRAS_LOG2;
  localparam logic [3:0]  CNT_INI = 4'(LATENCIA - 1);

  estado_t     estado_q, estado_d;
  logic [3:0]  cont_q, cont_d;
  logic [31:0] leitura_q, leitura_d;
  logic [31:0] dado_wb_q, dado_wb_d;
  logic [31:0] alu_wb_q, alu_wb_d;
  logic        reg_write_wb_q, reg_write_wb_d;
  logic        mem_to_reg_wb_q, mem_to_reg_wb_d;
  logic [4:0]  reg_dest_wb_q, reg_dest_wb_d;

  logic [31:0] mem [PROF];

  logic [PALAVRAS_LOG2-1:0] indice;
  logic acesso_mem;
  logic borda_acesso;
  logic desalinhado;
  logic escreve;
  logic parada;

  // Address bits above the memory depth are dropped, so accesses wrap.
  assign indice     = bus.aluOut[PALAVRAS_LOG2+1:2];
  assign acesso_mem = bus.memRead | bus.memWrite;

`ifdef MEM_ALINHAMENTO_EN
  assign desalinhado = |bus.aluOut[1:0];
`else
  assign desalinhado = 1'b0;
`endif

  assign borda_acesso = (estado_q == ACESSO) && (cont_q == 4'd0);
  assign escreve      = borda_acesso && bus.memWrite && !desalinhado;

  // Gated by reset so the stall drops the instant reset is asserted.
  assign parada = reset && (((estado_q == OCIOSO) && acesso_mem) || (estado_q == ACESSO));

  always_comb begin
    estado_d        = estado_q;
    cont_d          = cont_q;
    leitura_d       = leitura_q;
    dado_wb_d       = dado_wb_q;
    alu_wb_d        = alu_wb_q;
    reg_write_wb_d  = reg_write_wb_q;
    mem_to_reg_wb_d = mem_to_reg_wb_q;
    reg_dest_wb_d   = reg_dest_wb_q;

    case (estado_q)
      OCIOSO: begin
        if (acesso_mem) begin
          estado_d = ACESSO;
          cont_d   = CNT_INI;
        end
      end
      ACESSO: begin
        if (cont_q == 4'd0) begin
          estado_d  = CONCLUIDO;
          // A combined read/write returns 0, as does a suppressed misaligned access.
          leitura_d = (bus.memRead && !bus.memWrite && !desalinhado) ? mem[indice] : 32'd0;
        end else begin
          cont_d = cont_q - 4'd1;
        end
      end
      CONCLUIDO: estado_d = OCIOSO;
      default:   estado_d = OCIOSO;
    endcase

    if (parada) begin
      reg_write_wb_d  = 1'b0;
      mem_to_reg_wb_d = 1'b0;
    end else begin
      alu_wb_d        = bus.aluOut;
      reg_write_wb_d  = bus.regWrite;
      mem_to_reg_wb_d = bus.memToReg;
      reg_dest_wb_d   = bus.regDest;
      dado_wb_d       = (estado_q == CONCLUIDO) ? leitura_q : 32'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q        <= OCIOSO;
      cont_q          <= 4'd0;
      leitura_q       <= 32'd0;
      dado_wb_q       <= 32'd0;
      alu_wb_q        <= 32'd0;
      reg_write_wb_q  <= 1'b0;
      mem_to_reg_wb_q <= 1'b0;
      reg_dest_wb_q   <= 5'd0;
    end else begin
      estado_q        <= estado_d;
      cont_q          <= cont_d;
      leitura_q       <= leitura_d;
      dado_wb_q       <= dado_wb_d;
      alu_wb_q        <= alu_wb_d;
      reg_write_wb_q  <= reg_write_wb_d;
      mem_to_reg_wb_q <= mem_to_reg_wb_d;
      reg_dest_wb_q   <= reg_dest_wb_d;
    end
  end

  // Storage is never reset; reset forces OCIOSO so an aborted access cannot write.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem[indice] <= bus.reg2;
    end
  end

`ifdef MEM_ALINHAMENTO_EN
  logic erro_q, erro_d;

  assign erro_d = !parada && (estado_q == CONCLUIDO) && desalinhado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign bus.erroAlinhamento = erro_q;
`else
  assign bus.erroAlinhamento = 1'b0;
`endif

  assign bus.ctrlDesvio = (bus.branch & bus.zero) | bus.jump;
  assign bus.pcDestino  = bus.jump ? bus.pcJump : bus.pcDesvio;
  assign bus.parada     = parada;
  assign bus.dadoMemWB  = dado_wb_q;
  assign bus.aluOutWB   = alu_wb_q;
  assign bus.regWriteWB = reg_write_wb_q;
  assign bus.memToRegWB = mem_to_reg_wb_q;
  assign bus.regDestWB  = reg_dest_wb_q;

endmodule

// File: tb/tb_estagio_mem.sv
// Scoreboard bench for estagio_mem: the driver issues instructions and pushes expected MEM/WB
// contents; a negedge monitor pops and compares whenever MEM/WB loads a real instruction.
module tb_estagio_mem;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  estagio_mem_if bus();

  estagio_mem #(.LATENCIA(LAT), .PALAVRAS_LOG2(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] dado;
    logic [31:0] alu;
    logic        rw;
    logic        m2r;
    logic        erro;
    logic [4:0]  rd;
  } wb_t;

  typedef struct {
    string       nome;
    logic [31:0] act;
    logic [31:0] exp;
  } side_t;

  wb_t   sb[$];
  side_t side[$];
  int    total = 0;
  int    bad   = 0;
  logic  mon_on = 1'b0;
  logic [31:0] modelo [256];

  task automatic chk(input string nome, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nome, a, e, $time);
    end
  endtask

  task automatic push_side(input string nome, input logic [31:0] a, input logic [31:0] e);
    side_t s;
    s.nome = nome;
    s.act  = a;
    s.exp  = e;
    side.push_back(s);
  endtask

  // Monitor: sole owner of the counters.
  logic  was_on = 1'b0;
  logic  prev_p = 1'b1;
  wb_t   hold;
  wb_t   e_m;
  side_t s_m;

  always @(negedge clock) begin
    while (side.size() > 0) begin
      s_m = side.pop_front();
      chk(s_m.nome, s_m.act, s_m.exp);
    end
    if (mon_on && !was_on) begin
      hold.dado = 32'd0; hold.alu = 32'd0; hold.rw = 1'b0;
      hold.m2r = 1'b0; hold.erro = 1'b0; hold.rd = 5'd0;
      prev_p = bus.parada;
    end else if (mon_on) begin
      if (!prev_p) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e_m = sb.pop_front();
          chk("dadoMemWB",  bus.dadoMemWB, e_m.dado);
          chk("aluOutWB",   bus.aluOutWB, e_m.alu);
          chk("regWriteWB", 32'(bus.regWriteWB), 32'(e_m.rw));
          chk("memToRegWB", 32'(bus.memToRegWB), 32'(e_m.m2r));
          chk("regDestWB",  32'(bus.regDestWB), 32'(e_m.rd));
          chk("erroAlin",   32'(bus.erroAlinhamento), 32'(e_m.erro));
          hold = e_m;
        end
      end else begin
        chk("bolha_regWrite", 32'(bus.regWriteWB), 32'd0);
        chk("bolha_memToReg", 32'(bus.memToRegWB), 32'd0);
        chk("bolha_dado",     bus.dadoMemWB, hold.dado);
        chk("bolha_alu",      bus.aluOutWB, hold.alu);
        chk("bolha_regDest",  32'(bus.regDestWB), 32'(hold.rd));
        chk("bolha_erro",     32'(bus.erroAlinhamento), 32'd0);
      end
      prev_p = bus.parada;
    end
    was_on = mon_on;
  end

  task automatic set_in(input logic [31:0] alu, r2, pcd, pcj,
                        input logic z, rw, br, jp, mr, mw, m2r, input logic [4:0] rd);
    bus.aluOut = alu; bus.reg2 = r2; bus.pcDesvio = pcd; bus.pcJump = pcj;
    bus.zero = z; bus.regWrite = rw; bus.branch = br; bus.jump = jp;
    bus.memRead = mr; bus.memWrite = mw; bus.memToReg = m2r; bus.regDest = rd;
  endtask

  // Called at posedge+2; returns at posedge+2 after the instruction has been accepted.
  task automatic issue(input logic [31:0] alu, r2, pcd, pcj,
                       input logic z, rw, br, jp, mr, mw, m2r, input logic [4:0] rd);
    wb_t  e;
    logic mis;
    logic p;
    int   n;
    int   stalls;
    set_in(alu, r2, pcd, pcj, z, rw, br, jp, mr, mw, m2r, rd);
    #1;
    push_side("ctrlDesvio", 32'(bus.ctrlDesvio), 32'((br & z) | jp));
    push_side("pcDestino", bus.pcDestino, jp ? pcj : pcd);
`ifdef MEM_ALINHAMENTO_EN
    mis = (alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e.alu = alu; e.rw = rw; e.m2r = m2r; e.rd = rd;
    e.dado = 32'd0; e.erro = 1'b0;
    if (mr || mw) begin
      if (mw && !mis) modelo[alu[9:2]] = r2;
      if (mr && !mw && !mis) e.dado = modelo[alu[9:2]];
      e.erro = mis;
    end
    sb.push_back(e);
    n = 0; stalls = 0;
    do begin
      @(negedge clock);
      p = bus.parada;
      @(posedge clock);
      #2;
      if (p) stalls++;
      n++;
    end while (p && n < 40);
    if (p) push_side("timeout_parada", 32'd1, 32'd0);
    push_side("ciclos_parada", 32'(stalls), (mr || mw) ? 32'(LAT + 1) : 32'd0);
  endtask

  task automatic drain();
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    #1;
    push_side("sb_vazio", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    push_side({tag, "_parada"},     32'(bus.parada), 32'd0);
    push_side({tag, "_dado"},       bus.dadoMemWB, 32'd0);
    push_side({tag, "_alu"},        bus.aluOutWB, 32'd0);
    push_side({tag, "_regWrite"},   32'(bus.regWriteWB), 32'd0);
    push_side({tag, "_memToReg"},   32'(bus.memToRegWB), 32'd0);
    push_side({tag, "_regDest"},    32'(bus.regDestWB), 32'd0);
    push_side({tag, "_erro"},       32'(bus.erroAlinhamento), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] alu, hi;
    logic [1:0]  lo;
    int          k, idx;

    set_in(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 256; i++) modelo[i] = 32'd0;
    @(posedge clock); @(posedge clock); #2;
    chk_reset_outs("reset_ini");
    @(posedge clock); #2;
    reset  = 1'b1;
    mon_on = 1'b1;

    // Store then load through the same word.
    issue(32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0);
    issue(32'h10, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd5);
    // Redirects.
    issue(32'h0, 32'h0, 32'h40, 32'h0, 1, 0, 1, 0, 0, 0, 0, 5'd0);
    issue(32'h0, 32'h0, 32'h40, 32'h80, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    // Address wrap: 0x400 aliases word 0.
    issue(32'h400, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0);
    issue(32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd9);
    // Misaligned store, then read back word 4.
    issue(32'h12, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0);
    issue(32'h10, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd3);
    // Read and write together.
    issue(32'h14, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 1, 1, 1, 5'd4);
    issue(32'h14, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd6);

    for (int i = 0; i < 16; i++)
      issue(32'(i << 2), $urandom, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0);

    for (int i = 0; i < 60; i++) begin
      k   = $urandom_range(0, 4);
      idx = $urandom_range(0, 15);
      hi  = $urandom & 32'hFFFF_FC00;
      lo  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      alu = hi | 32'(idx << 2) | {30'd0, lo};
      case (k)
        0: issue(alu, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 5'($urandom));
        1: issue(alu, $urandom, $urandom, $urandom, 0, 1, 0, 0, 1, 0, 1, 5'($urandom));
        2: issue(alu, $urandom, $urandom, $urandom, 0, 0, 0, 0, 0, 1, 0, 5'($urandom));
        3: issue(alu, $urandom, $urandom, $urandom, 0, 1, 0, 0, 1, 1, 1, 5'($urandom));
        default: issue(alu, $urandom, $urandom, $urandom, 1'($urandom), 0, 1'($urandom), 1'($urandom), 0, 0, 0, 5'($urandom));
      endcase
    end
    drain();

    // Reset in the second ACESSO cycle of a store aborts it.
    set_in(32'h1C, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0);
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("reset_acesso");
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clock); #2;
    reset  = 1'b1;
    mon_on = 1'b1;
    issue(32'h1C, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd7);
    drain();

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
